// File: rtl/pipe_skid_buffer.sv
// Two-entry elastic pipeline stage (main + skid register) with a registered
// upstream ready, so S_READY never combinationally depends on M_READY.
// COUNT doubles as the FSM state: 0 = EMPTY, 1 = BUSY, 2 = FULL.
module pipe_skid_buffer #(
  parameter int             N    = 32,
  parameter logic [N-1:0]   INIT = '0
) (
  input  logic         C,
  input  logic         R,
  input  logic         FLUSH,
  input  logic         S_VALID,
  output logic         S_READY,
  input  logic [N-1:0] S_DATA,
  output logic         M_VALID,
  input  logic         M_READY,
  output logic [N-1:0] M_DATA,
  output logic [1:0]   COUNT
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] BUSY  = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  logic [1:0]   state_q, state_d;
  logic         s_ready_q, s_ready_d;
  logic [N-1:0] main_q, main_d;
  logic [N-1:0] skid_q, skid_d;
  logic         in_xfer, out_xfer;

  assign in_xfer  = S_VALID & s_ready_q;
  assign out_xfer = (state_q != EMPTY) & M_READY;

  // State and registered ready; reset wins over flush.
  always_ff @(posedge C) begin
    if (R) begin
      state_q   <= EMPTY;
      s_ready_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      s_ready_q <= s_ready_d;
    end
  end

  // Next-state: flush drops everything, otherwise follow the handshakes.
  always_comb begin
    state_d = state_q;
    if (FLUSH) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (in_xfer) state_d = BUSY;
        BUSY: begin
          if (in_xfer && !out_xfer)      state_d = FULL;
          else if (!in_xfer && out_xfer) state_d = EMPTY;
        end
        FULL:    if (out_xfer) state_d = BUSY;
        default: state_d = EMPTY;
      endcase
    end
    s_ready_d = (state_d != FULL);
  end

  // Outputs are pure functions of the registered state.
  always_comb begin
    M_VALID = (state_q != EMPTY);
    S_READY = s_ready_q;
    COUNT   = state_q;
    M_DATA  = main_q;
  end

  // Data-path loads; flush cycles load nothing so handshakes there are lost.
  always_comb begin
    main_d = main_q;
    skid_d = skid_q;
    if (!FLUSH) begin
      case (state_q)
        EMPTY: if (in_xfer) main_d = S_DATA;
        BUSY: begin
          if (in_xfer && out_xfer)  main_d = S_DATA;
          if (in_xfer && !out_xfer) skid_d = S_DATA;
        end
        FULL:    if (out_xfer) main_d = skid_q;
        default: ;
      endcase
    end
  end

  // Data registers reload INIT on reset and otherwise hold unless loaded.
  always_ff @(posedge C) begin
    if (R) begin
      main_q <= INIT;
      skid_q <= INIT;
    end else begin
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end

endmodule
